fg_prog_sequencer: RTL and testbench
====================================

FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ROW_BITS, 6, vertical decoder address width
- COL_BITS, 6, horizontal decoder address width
- ISL_BITS, 1, island select width
- PW_BITS, 16, pulse-width field width
- CNT_BITS, 8, pulse-count field width
- SETUP_CYC, 16, address-settle cycles
- GAP_CYC, 8, inter-pulse cycles
- MAX_ROW, 12, first illegal row
- MAX_COL, 26, first illegal col

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_island  in  ISL_BITS  target island
- cmd_row  in  ROW_BITS  target row
- cmd_col  in  COL_BITS  target column
- cmd_pw  in  PW_BITS  injection pulse width in cycles
- cmd_cnt  in  CNT_BITS  number of pulses
- abort  in  1  terminate current command
- isl_sel  out  ISL_BITS  island select to programming mux
- row_addr  out  ROW_BITS  to vertical VinjDecode2to4 tile chain
- col_addr  out  COL_BITS  to horizontal VinjDecode2to4 tile chain
- dec_en  out  1  decoder enable
- drain_sel  out  1  drainSelect enable
- vinj_pulse  out  1  injection pulse
- busy  out  1  command in progress
- done  out  1  one-cycle completion strobe
- err  out  1  one-cycle rejection strobe

Function
REQ-003 SHALL use FSM states IDLE, SETUP, PULSE, GAP, RELEASE; all outputs registered.
REQ-004 IDLE: cmd_ready=1; on handshake with row<MAX_ROW and col<MAX_COL, latch fields, drive isl_sel/row_addr/col_addr and assert dec_en next cycle, go SETUP.
REQ-005 On handshake with row>=MAX_ROW or col>=MAX_COL: err=1 for one cycle, stay IDLE, address outputs unchanged.
REQ-006 SETUP SHALL last exactly SETUP_CYC cycles, drain_sel=1 from its first cycle; then PULSE if cnt>0, else RELEASE.
REQ-007 PULSE: vinj_pulse=1 for max(cmd_pw,1) cycles (cmd_pw=0 treated as 1); decrement remaining count on exit.
REQ-008 After PULSE: GAP (vinj_pulse=0, drain_sel=1) for GAP_CYC cycles if remaining count>0, then PULSE; else RELEASE.
REQ-009 RELEASE: 1 cycle, vinj_pulse=0, drain_sel=0, dec_en=0; then done=1 for one cycle coinciding with return to IDLE.
REQ-010 cmd_ready=0 and busy=1 in every state except IDLE.
REQ-011 vinj_pulse SHALL never be 1 while dec_en=0 or drain_sel=0.
REQ-012 abort in SETUP/PULSE/GAP: next state RELEASE; vinj_pulse low the next cycle; done still strobes. abort in IDLE/RELEASE ignored.
REQ-013 Counters SHALL not wrap: pulse-width counter PW_BITS wide, count CNT_BITS wide; cnt=2^CNT_BITS-1 gives exactly that many pulses.
REQ-014 Address outputs SHALL hold their last value in IDLE (dec_en=0 gates them).

Reset
REQ-015 Asynchronous reset SHALL force IDLE and all outputs to 0 except cmd_ready=1; reset mid-PULSE drops vinj_pulse immediately, with no done strobe.

Structure
REQ-016 State enum, field-width constants, MAX_ROW/MAX_COL defaults SHALL live in shared package fpaa_prog_pkg.
REQ-017 One sub-module fg_prog_timer (loadable down-counter with zero flag) SHALL be shared by SETUP, PULSE and GAP timing.

Verification
REQ-018 row=3, col=5, pw=4, cnt=2 -> dec_en at cycle 1; vinj high cycles 17-20 and 29-32; done at cycle 34.
REQ-019 row=12 (MAX_ROW) -> err 1 cycle, busy stays 0, no dec_en.
REQ-020 cnt=0 -> SETUP then RELEASE; vinj_pulse never asserts; done at cycle 18.
REQ-021 abort during second cycle of PULSE -> vinj_pulse low the next cycle, RELEASE, done strobe; next command accepted.
REQ-022 reset asserted mid-GAP -> all outputs 0 asynchronously, cmd_ready=1 after release, no done.
REQ-023 pw=0, cnt=1 -> exactly one 1-cycle vinj pulse; back-to-back cmd_valid held -> second command accepted the cycle after done.

Source files
------------

// File: rtl/fpaa_prog_pkg.sv
// Shared definitions for the FPAA floating-gate programming sequencer:
// FSM state encoding, default field widths, timing and address limits.
package fpaa_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        RELEASE
    } prog_state_t;

    localparam int ROW_BITS_DEF  = 6;
    localparam int COL_BITS_DEF  = 6;
    localparam int ISL_BITS_DEF  = 1;
    localparam int PW_BITS_DEF   = 16;
    localparam int CNT_BITS_DEF  = 8;
    localparam int SETUP_CYC_DEF = 16;
    localparam int GAP_CYC_DEF   = 8;
    localparam int MAX_ROW_DEF   = 12;
    localparam int MAX_COL_DEF   = 26;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter with a zero flag; it holds at zero until it is reloaded.
module fg_prog_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: selects a cell through the decoder chains,
// then issues a train of injection pulses separated by drain-held gaps.
module fg_prog_sequencer
    import fpaa_prog_pkg::*;
#(
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int COL_BITS  = COL_BITS_DEF,
    parameter int ISL_BITS  = ISL_BITS_DEF,
    parameter int PW_BITS   = PW_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF,
    parameter int MAX_ROW   = MAX_ROW_DEF,
    parameter int MAX_COL   = MAX_COL_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ISL_BITS-1:0] cmd_island,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [PW_BITS-1:0]  cmd_pw,
    input  logic [CNT_BITS-1:0] cmd_cnt,
    input  logic                abort,
    output logic [ISL_BITS-1:0] isl_sel,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [COL_BITS-1:0] col_addr,
    output logic                dec_en,
    output logic                drain_sel,
    output logic                vinj_pulse,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int TMR_BITS = max3(PW_BITS, $clog2(SETUP_CYC + 1), $clog2(GAP_CYC + 1));
    localparam logic [TMR_BITS-1:0] SETUP_M1  = TMR_BITS'(SETUP_CYC - 1);
    localparam logic [TMR_BITS-1:0] GAP_M1    = TMR_BITS'(GAP_CYC - 1);
    localparam logic [PW_BITS-1:0]  PW_ONE    = PW_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [ROW_BITS:0]   ROW_LIMIT = (ROW_BITS + 1)'(MAX_ROW);
    localparam logic [COL_BITS:0]   COL_LIMIT = (COL_BITS + 1)'(MAX_COL);

    prog_state_t         state;
    logic [PW_BITS-1:0]  pw_q;
    logic [CNT_BITS-1:0] rem_q;
    logic [PW_BITS-1:0]  plen_m1;
    logic                cmd_legal;
    logic                tmr_load;
    logic [TMR_BITS-1:0] tmr_val;
    logic                tmr_zero;

    // The extra top bit keeps the limit compare correct when a limit equals 2^width.
    assign cmd_legal = ({1'b0, cmd_row} < ROW_LIMIT) && ({1'b0, cmd_col} < COL_LIMIT);
    assign plen_m1   = (pw_q == '0) ? '0 : pw_q - PW_ONE;

    // The timer is reloaded on the last cycle of each timed phase so that it holds
    // length-1 on the first cycle of the following phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE, RELEASE: begin
                tmr_load = 1'b1;
                tmr_val  = SETUP_M1;
            end
            SETUP, GAP: begin
                tmr_load = tmr_zero;
                tmr_val  = TMR_BITS'(plen_m1);
            end
            PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = GAP_M1;
            end
            default: begin
                tmr_load = 1'b1;
                tmr_val  = SETUP_M1;
            end
        endcase
    end

    fg_prog_timer #(
        .WIDTH(TMR_BITS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // Outputs are set on the edge entering each state, so every entry into RELEASE
    // drops the pulse, drain and decoder enable together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pw_q       <= '0;
            rem_q      <= '0;
            cmd_ready  <= 1'b1;
            isl_sel    <= '0;
            row_addr   <= '0;
            col_addr   <= '0;
            dec_en     <= 1'b0;
            drain_sel  <= 1'b0;
            vinj_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            pw_q      <= cmd_pw;
                            rem_q     <= cmd_cnt;
                            isl_sel   <= cmd_island;
                            row_addr  <= cmd_row;
                            col_addr  <= cmd_col;
                            dec_en    <= 1'b1;
                            drain_sel <= 1'b1;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            state     <= SETUP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (abort || (tmr_zero && rem_q == '0)) begin
                        dec_en     <= 1'b0;
                        drain_sel  <= 1'b0;
                        vinj_pulse <= 1'b0;
                        state      <= RELEASE;
                    end else if (tmr_zero) begin
                        vinj_pulse <= 1'b1;
                        state      <= PULSE;
                    end
                end
                PULSE: begin
                    if (abort) begin
                        dec_en     <= 1'b0;
                        drain_sel  <= 1'b0;
                        vinj_pulse <= 1'b0;
                        state      <= RELEASE;
                    end else if (tmr_zero) begin
                        rem_q      <= rem_q - CNT_ONE;
                        vinj_pulse <= 1'b0;
                        if (rem_q != CNT_ONE) begin
                            state <= GAP;
                        end else begin
                            dec_en    <= 1'b0;
                            drain_sel <= 1'b0;
                            state     <= RELEASE;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        dec_en     <= 1'b0;
                        drain_sel  <= 1'b0;
                        vinj_pulse <= 1'b0;
                        state      <= RELEASE;
                    end else if (tmr_zero) begin
                        vinj_pulse <= 1'b1;
                        state      <= PULSE;
                    end
                end
                RELEASE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    dec_en     <= 1'b0;
                    drain_sel  <= 1'b0;
                    vinj_pulse <= 1'b0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: directed scenarios plus random
// commands compared cycle by cycle against a timeline model of the pulse train.
module tb_fg_prog_sequencer;

    localparam int ROW_BITS  = 6;
    localparam int COL_BITS  = 6;
    localparam int ISL_BITS  = 1;
    localparam int PW_BITS   = 16;
    localparam int CNT_BITS  = 8;
    localparam int SETUP_CYC = 16;
    localparam int GAP_CYC   = 8;
    localparam int MAX_ROW   = 12;
    localparam int MAX_COL   = 26;
    localparam int AW        = ISL_BITS + ROW_BITS + COL_BITS;

    // {vinj_pulse, dec_en, drain_sel, busy, cmd_ready, done, err}
    localparam logic [6:0] IDLE_VEC = 7'b0000100;
    localparam logic [6:0] ERR_VEC  = 7'b0000101;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [ISL_BITS-1:0] cmd_island = '0;
    logic [ROW_BITS-1:0] cmd_row = '0;
    logic [COL_BITS-1:0] cmd_col = '0;
    logic [PW_BITS-1:0]  cmd_pw = '0;
    logic [CNT_BITS-1:0] cmd_cnt = '0;
    logic                abort = 1'b0;
    logic [ISL_BITS-1:0] isl_sel;
    logic [ROW_BITS-1:0] row_addr;
    logic [COL_BITS-1:0] col_addr;
    logic                dec_en;
    logic                drain_sel;
    logic                vinj_pulse;
    logic                busy;
    logic                done;
    logic                err;

    int checks = 0;
    int failures = 0;
    int last_isl = 0;
    int last_row = 0;
    int last_col = 0;

    wire [6:0]    obs      = {vinj_pulse, dec_en, drain_sel, busy, cmd_ready, done, err};
    wire [AW-1:0] obs_addr = {isl_sel, row_addr, col_addr};

    fg_prog_sequencer #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .ISL_BITS (ISL_BITS),
        .PW_BITS  (PW_BITS),
        .CNT_BITS (CNT_BITS),
        .SETUP_CYC(SETUP_CYC),
        .GAP_CYC  (GAP_CYC),
        .MAX_ROW  (MAX_ROW),
        .MAX_COL  (MAX_COL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_island(cmd_island),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_pw    (cmd_pw),
        .cmd_cnt   (cmd_cnt),
        .abort     (abort),
        .isl_sel   (isl_sel),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .dec_en    (dec_en),
        .drain_sel (drain_sel),
        .vinj_pulse(vinj_pulse),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Cycle (counted from the handshake cycle = 0) on which done strobes.
    function automatic int m_done_t(input int pw, input int cnt, input int abort_t);
        int plen;
        int normal;
        plen   = (pw == 0) ? 1 : pw;
        normal = (cnt == 0) ? SETUP_CYC + 2
                            : SETUP_CYC + cnt * plen + (cnt - 1) * GAP_CYC + 2;
        if (abort_t >= 1 && abort_t <= normal - 2) return abort_t + 2;
        return normal;
    endfunction

    // Expected output vector at cycle t of an accepted command.
    function automatic logic [6:0] m_vec(input int t, input int pw, input int cnt, input int abort_t);
        int   plen;
        int   d;
        int   u;
        logic act;
        logic bsy;
        logic v;
        plen = (pw == 0) ? 1 : pw;
        d    = m_done_t(pw, cnt, abort_t);
        u    = t - (SETUP_CYC + 1);
        act  = (t >= 1) && (t <= d - 2);
        bsy  = (t >= 1) && (t <= d - 1);
        v    = act && (u >= 0) && ((u / (plen + GAP_CYC)) < cnt) && ((u % (plen + GAP_CYC)) < plen);
        return {v, act, act, bsy, ~bsy, (t == d), 1'b0};
    endfunction

    function automatic logic [AW-1:0] m_addr(input int isl, input int row, input int col);
        return {ISL_BITS'(isl), ROW_BITS'(row), COL_BITS'(col)};
    endfunction

    task automatic start_cmd(input int isl, input int row, input int col, input int pw, input int cnt);
        cmd_island = ISL_BITS'(isl);
        cmd_row    = ROW_BITS'(row);
        cmd_col    = COL_BITS'(col);
        cmd_pw     = PW_BITS'(pw);
        cmd_cnt    = CNT_BITS'(cnt);
        cmd_valid  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, IDLE_VEC);
        end
        checks++;
        if (obs_addr !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%h exp=0", obs_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got=%b exp=%b", obs, IDLE_VEC);
        end
        last_isl = 0; last_row = 0; last_col = 0;
    endtask

    task automatic test_basic();
        int first_v;
        int last_v;
        int n_v;
        int done_at;
        first_v = -1; last_v = -1; n_v = 0; done_at = -1;
        start_cmd(1, 3, 5, 4, 2);
        for (int t = 1; t <= 36; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (obs !== m_vec(t, 4, 2, 0)) begin
                failures++;
                $display("[TB] FAIL basic_vec t=%0d got=%b exp=%b", t, obs, m_vec(t, 4, 2, 0));
            end
            if (t == 1) begin
                checks++;
                if (obs_addr !== m_addr(1, 3, 5)) begin
                    failures++;
                    $display("[TB] FAIL basic_addr got=%h exp=%h", obs_addr, m_addr(1, 3, 5));
                end
            end
            if (vinj_pulse === 1'b1) begin
                if (first_v < 0) first_v = t;
                last_v = t;
                n_v++;
            end
            if (done === 1'b1) done_at = t;
        end
        checks++;
        if (first_v != 17 || last_v != 32 || n_v != 8) begin
            failures++;
            $display("[TB] FAIL basic_vinj_window got=%0d..%0d n=%0d exp=17..32 n=8", first_v, last_v, n_v);
        end
        checks++;
        if (done_at != 34) begin
            failures++;
            $display("[TB] FAIL basic_done_cycle got=%0d exp=34", done_at);
        end
        checks++;
        if (obs_addr !== m_addr(1, 3, 5)) begin
            failures++;
            $display("[TB] FAIL basic_addr_hold got=%h exp=%h", obs_addr, m_addr(1, 3, 5));
        end
        last_isl = 1; last_row = 3; last_col = 5;
    endtask

    task automatic test_illegal();
        logic [6:0] exp;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_cmd(0, MAX_ROW, 4, 3, 1);
            else        start_cmd(0, 0, MAX_COL, 3, 1);
            for (int t = 1; t <= 3; t++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                exp = (t == 1) ? ERR_VEC : IDLE_VEC;
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("[TB] FAIL illegal%0d_vec t=%0d got=%b exp=%b", k, t, obs, exp);
                end
            end
            checks++;
            if (obs_addr !== m_addr(last_isl, last_row, last_col)) begin
                failures++;
                $display("[TB] FAIL illegal%0d_addr got=%h exp=%h", k, obs_addr, m_addr(last_isl, last_row, last_col));
            end
        end
        start_cmd(1, MAX_ROW - 1, MAX_COL - 1, 0, 0);
        for (int t = 1; t <= 19; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (obs !== m_vec(t, 0, 0, 0)) begin
                failures++;
                $display("[TB] FAIL edge_legal_vec t=%0d got=%b exp=%b", t, obs, m_vec(t, 0, 0, 0));
            end
        end
        checks++;
        if (obs_addr !== m_addr(1, MAX_ROW - 1, MAX_COL - 1)) begin
            failures++;
            $display("[TB] FAIL edge_legal_addr got=%h exp=%h", obs_addr, m_addr(1, MAX_ROW - 1, MAX_COL - 1));
        end
        last_isl = 1; last_row = MAX_ROW - 1; last_col = MAX_COL - 1;
    endtask

    task automatic test_zero_cnt();
        int n_v;
        int done_at;
        n_v = 0; done_at = -1;
        start_cmd(0, 7, 9, 3, 0);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (obs !== m_vec(t, 3, 0, 0)) begin
                failures++;
                $display("[TB] FAIL zero_cnt_vec t=%0d got=%b exp=%b", t, obs, m_vec(t, 3, 0, 0));
            end
            if (vinj_pulse === 1'b1) n_v++;
            if (done === 1'b1) done_at = t;
        end
        checks++;
        if (n_v != 0 || done_at != 18) begin
            failures++;
            $display("[TB] FAIL zero_cnt_summary pulses=%0d done=%0d exp pulses=0 done=18", n_v, done_at);
        end
        last_isl = 0; last_row = 7; last_col = 9;
    endtask

    task automatic test_abort();
        int d2;
        start_cmd(1, 4, 6, 4, 2);
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (obs !== m_vec(t, 4, 2, 18)) begin
                failures++;
                $display("[TB] FAIL abort_vec t=%0d got=%b exp=%b", t, obs, m_vec(t, 4, 2, 18));
            end
            if (t == 20) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL abort_done got=%b exp=1", done);
                end
            end
            abort = (t == 18);
        end
        abort = 1'b0;
        d2 = m_done_t(1, 1, 0);
        start_cmd(0, 1, 2, 1, 1);
        for (int t = 1; t <= d2 + 1; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++;
            if (obs !== m_vec(t, 1, 1, 0)) begin
                failures++;
                $display("[TB] FAIL after_abort_vec t=%0d got=%b exp=%b", t, obs, m_vec(t, 1, 1, 0));
            end
        end
        last_isl = 0; last_row = 1; last_col = 2;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            start_cmd(1, 5, 8, 2, 3);
            for (int t = 1; t <= ((k == 0) ? 22 : 18); t++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                checks++;
                if (obs !== m_vec(t, 2, 3, 0)) begin
                    failures++;
                    $display("[TB] FAIL reset_mid%0d_pre t=%0d got=%b exp=%b", k, t, obs, m_vec(t, 2, 3, 0));
                end
            end
            #1 reset = 1'b1;
            #1;
            checks++;
            if (obs !== IDLE_VEC || obs_addr !== '0) begin
                failures++;
                $display("[TB] FAIL reset_mid%0d_async got=%b/%h exp=%b/0", k, obs, obs_addr, IDLE_VEC);
            end
            @(negedge clk);
            reset = 1'b0;
            for (int t = 1; t <= 30; t++) begin
                @(negedge clk);
                checks++;
                if (obs !== IDLE_VEC) begin
                    failures++;
                    $display("[TB] FAIL reset_mid%0d_after t=%0d got=%b exp=%b", k, t, obs, IDLE_VEC);
                end
            end
        end
        last_isl = 0; last_row = 0; last_col = 0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int n_v;
        n_v = 0;
        start_cmd(0, 2, 7, 0, 1);
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            exp = (t <= 19) ? m_vec(t, 0, 1, 0) : m_vec(t - 19, 0, 1, 0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL b2b_vec t=%0d got=%b exp=%b", t, obs, exp);
            end
            if (vinj_pulse === 1'b1) n_v++;
            if (t == 20) cmd_valid = 1'b0;
        end
        checks++;
        if (n_v != 2) begin
            failures++;
            $display("[TB] FAIL b2b_pulse_cycles got=%0d exp=2", n_v);
        end
        last_isl = 0; last_row = 2; last_col = 7;
    endtask

    task automatic test_long();
        int d;
        int pulses;
        int run;
        logic prev;
        for (int k = 0; k < 2; k++) begin
            int pw;
            int cnt;
            pw  = (k == 0) ? 0 : 300;
            cnt = (k == 0) ? 255 : 1;
            d = m_done_t(pw, cnt, 0);
            pulses = 0; run = 0; prev = 1'b0;
            start_cmd(1, 10, 20, pw, cnt);
            for (int t = 1; t <= d + 1; t++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                checks++;
                if (obs !== m_vec(t, pw, cnt, 0)) begin
                    failures++;
                    $display("[TB] FAIL long%0d_vec t=%0d got=%b exp=%b", k, t, obs, m_vec(t, pw, cnt, 0));
                end
                if (vinj_pulse === 1'b1 && !prev) pulses++;
                if (vinj_pulse === 1'b1) run++;
                prev = (vinj_pulse === 1'b1);
            end
            checks++;
            if (pulses != cnt || run != cnt * ((pw == 0) ? 1 : pw)) begin
                failures++;
                $display("[TB] FAIL long%0d_count pulses=%0d high=%0d exp=%0d/%0d", k, pulses, run, cnt, cnt * ((pw == 0) ? 1 : pw));
            end
        end
        last_isl = 1; last_row = 10; last_col = 20;
    endtask

    task automatic test_random();
        logic [6:0]    exp;
        logic [AW-1:0] exp_addr;
        for (int n = 0; n < 30; n++) begin
            int  isl;
            int  row;
            int  col;
            int  pw;
            int  cnt;
            int  abort_t;
            int  d;
            bit  legal;
            isl     = $urandom_range(0, 1);
            row     = $urandom_range(0, 15);
            col     = $urandom_range(0, 31);
            pw      = $urandom_range(0, 6);
            cnt     = $urandom_range(0, 4);
            abort_t = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 45) : 0;
            legal   = (row < MAX_ROW) && (col < MAX_COL);
            d       = legal ? m_done_t(pw, cnt, abort_t) : 1;
            start_cmd(isl, row, col, pw, cnt);
            for (int t = 1; t <= d + 1; t++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                exp = legal ? m_vec(t, pw, cnt, abort_t) : ((t == 1) ? ERR_VEC : IDLE_VEC);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_vec t=%0d row=%0d col=%0d pw=%0d cnt=%0d ab=%0d got=%b exp=%b",
                             n, t, row, col, pw, cnt, abort_t, obs, exp);
                end
                if (t == 1) begin
                    exp_addr = legal ? m_addr(isl, row, col) : m_addr(last_isl, last_row, last_col);
                    checks++;
                    if (obs_addr !== exp_addr) begin
                        failures++;
                        $display("[TB] FAIL rand%0d_addr got=%h exp=%h", n, obs_addr, exp_addr);
                    end
                end
                abort = legal && (t == abort_t);
            end
            abort = 1'b0;
            if (legal) begin
                last_isl = isl; last_row = row; last_col = col;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_zero_cnt();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_long();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
